// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store + writeback stage.
// Holds Ld/St/Memtoreg codes, FSM states, lane masks and alignment helpers.
package lsu_pkg;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  localparam logic [1:0] MTR_LOAD = 2'b01;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_GNT    = 2'd1,
    S_WAIT_RVALID = 2'd2
  } lsu_state_e;

  // 110/111 are reserved and behave as "no load"
  function automatic logic is_load(input logic [2:0] ld);
    return (ld >= LD_LB) && (ld <= LD_LHU);
  endfunction

  // store type takes priority when both controls are set
  function automatic logic misaligned(
    input logic [2:0] ld,
    input logic [1:0] st,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    if (st != ST_NONE) begin
      case (st)
        ST_SH:   m = off[0];
        ST_SW:   m = |off;
        default: m = 1'b0;
      endcase
    end else begin
      case (ld)
        LD_LH, LD_LHU: m = off[0];
        LD_LW:         m = |off;
        default:       m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_wb_load_align.sv
// load_align: selects the byte/half at the access offset and extends it.
// Ports: i_rdata word, i_offset addr[1:0], i_ld_cntr load type, o_data result.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_ld_cntr,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_offset)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
    endcase
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    unique case (i_ld_cntr)
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LBU:  o_data = {24'h0, w_byte};
      LD_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// lsu_wb: load/store + writeback stage with req/gnt/rvalid memory port.
// Ports: EXE controls in, dmem_* bus, lsu_stall upstream, rf_* write, error pulses.
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] Rd2_exe2lsu,
  input  logic [1:0]       Memtoreg_exe2lsu,
  input  logic [2:0]       Ld_cntr_exe2lsu,
  input  logic [1:0]       St_cntr_exe2lsu,
  input  logic             RegW_exe2lsu,
  input  logic [4:0]       wr_addr_exe2lsu,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [3:0]       dmem_be,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic             lsu_stall,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             misalign_err,
  output logic             bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  lsu_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_sdata;
  logic [2:0]    r_ld;
  logic [1:0]    r_st;
  logic [1:0]    r_mtr;
  logic          r_regw;
  logic [4:0]    r_waddr;

  logic        w_st_in;
  logic        w_ld_in;
  logic        w_mem_in;
  logic        w_mis_in;
  logic        w_idle;
  logic        w_issue;
  logic        w_to;
  logic [1:0]  w_cur_st;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_sdata;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_req;
  logic        w_stall;
  logic [31:0] w_ld_data;

  assign w_st_in  = St_cntr_exe2lsu != ST_NONE;
  assign w_ld_in  = !w_st_in && is_load(Ld_cntr_exe2lsu);
  assign w_mem_in = w_st_in || w_ld_in;
  assign w_mis_in = w_mem_in && misaligned(Ld_cntr_exe2lsu,
                                           St_cntr_exe2lsu,
                                           alu_result[1:0]);
  assign w_idle   = r_state == S_IDLE;
  assign w_issue  = w_idle && w_mem_in && !w_mis_in;

  // watchdog fires on the last allowed wait cycle
  assign w_to = (TIMEOUT != 0) && !w_idle && (r_cnt == TO_LAST);

  // IDLE drives the bus straight from EXE; wait states replay the latch
  assign w_cur_st    = w_idle ? St_cntr_exe2lsu : r_st;
  assign w_cur_addr  = w_idle ? alu_result : r_addr;
  assign w_cur_sdata = w_idle ? Rd2_exe2lsu : r_sdata;

  always_comb begin
    w_be    = BE_WORD;
    w_wdata = '0;
    unique case (w_cur_st)
      ST_SB: begin
        w_be    = BE_BYTE << w_cur_addr[1:0];
        w_wdata = {4{w_cur_sdata[7:0]}};
      end
      ST_SH: begin
        w_be    = BE_HALF << w_cur_addr[1:0];
        w_wdata = {2{w_cur_sdata[15:0]}};
      end
      ST_SW: begin
        w_be    = BE_WORD;
        w_wdata = w_cur_sdata;
      end
      default: begin
        w_be    = BE_WORD;
        w_wdata = '0;
      end
    endcase
  end

  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req   = w_issue;
        w_stall = w_issue && !(w_st_in && dmem_gnt);
      end
      S_WAIT_GNT: begin
        w_req   = !w_to;
        w_stall = !w_to && !(dmem_gnt && r_st != ST_NONE);
      end
      S_WAIT_RVALID: begin
        w_stall = !dmem_rvalid && !w_to;
      end
      default: begin
        w_req   = 1'b0;
        w_stall = 1'b0;
      end
    endcase
  end

  // bus and stall are forced low while reset is held
  assign dmem_req   = w_req && rstn;
  assign lsu_stall  = w_stall && rstn;
  assign dmem_we    = dmem_req && (w_cur_st != ST_NONE);
  assign dmem_be    = dmem_req ? w_be : 4'h0;
  assign dmem_addr  = dmem_req ? {w_cur_addr[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = dmem_req ? w_wdata : 32'h0;

  load_align u_align (
    .i_rdata   (dmem_rdata),
    .i_offset  (r_addr[1:0]),
    .i_ld_cntr (r_ld),
    .o_data    (w_ld_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_sdata      <= '0;
      r_ld         <= LD_NONE;
      r_st         <= ST_NONE;
      r_mtr        <= '0;
      r_regw       <= 1'b0;
      r_waddr      <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      rf_we        <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_mis_in) begin
            misalign_err <= 1'b1;
          end else if (w_issue) begin
            r_addr  <= alu_result;
            r_sdata <= Rd2_exe2lsu;
            r_ld    <= Ld_cntr_exe2lsu;
            r_st    <= St_cntr_exe2lsu;
            r_mtr   <= Memtoreg_exe2lsu;
            r_regw  <= RegW_exe2lsu;
            r_waddr <= wr_addr_exe2lsu;
            r_cnt   <= '0;
            if (!dmem_gnt) begin
              r_state <= S_WAIT_GNT;
            end else if (!w_st_in) begin
              r_state <= S_WAIT_RVALID;
            end
          end else begin
            rf_we    <= RegW_exe2lsu && (wr_addr_exe2lsu != 5'd0);
            rf_waddr <= wr_addr_exe2lsu;
            rf_wdata <= alu_result;
          end
        end
        S_WAIT_GNT: begin
          if (w_to) begin
            bus_err <= 1'b1;
            r_state <= S_IDLE;
          end else if (dmem_gnt) begin
            r_cnt   <= '0;
            r_state <= (r_st != ST_NONE) ? S_IDLE : S_WAIT_RVALID;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_RVALID: begin
          if (dmem_rvalid) begin
            rf_we    <= r_regw && (r_waddr != 5'd0);
            rf_waddr <= r_waddr;
            rf_wdata <= (r_mtr == MTR_LOAD) ? w_ld_data : r_addr;
            r_state  <= S_IDLE;
          end else if (w_to) begin
            bus_err <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
Load/store + writeback stage, directly downstream of the execute stage in the 4-stage core. Consumes the registered ALU result, store data and LSU/writeback controls. Runs the data-memory req/gnt/rvalid handshake, aligns and extends load data, and produces the registered register-file write. Asserts a stall back to IF/ID/EXE while a memory access is outstanding.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.
TIMEOUT, 16, max cycles spent in a wait state before abort; 0 disables the watchdog.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
alu_result  in  32  effective address or ALU value from EXE
Rd2_exe2lsu  in  32  store data
Memtoreg_exe2lsu  in  2  writeback source select
Ld_cntr_exe2lsu  in  3  load type
St_cntr_exe2lsu  in  2  store type
RegW_exe2lsu  in  1  register write enable
wr_addr_exe2lsu  in  5  destination register
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_be  out  4  byte enables
dmem_addr  out  32  word address; [1:0] = 0
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load data word
lsu_stall  out  1  hold upstream stages
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile address
rf_wdata  out  32  regfile data
misalign_err  out  1  one-cycle pulse: misaligned access dropped
bus_err  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Ports: one clock clk; reset rstn is asynchronous, active-low. Reset: state IDLE, watchdog count 0, all registered outputs 0 (rf_*, misalign_err, bus_err); dmem_req/lsu_stall 0.
- Encodings: Ld_cntr 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110/111 treated as none. St_cntr 00 none, 01 SB, 10 SH, 11 SW. Memtoreg 01 selects load data; all other values select alu_result. Ld and St both non-zero: store wins.
- Non-memory op: rf_we/rf_waddr/rf_wdata are registered with 1-cycle latency. rf_we = RegW && wr_addr != 0. No stall.
- Alignment: LH/LHU/SH need addr[0] = 0. LW/SW need addr[1:0] = 0. On a misaligned access: no bus request, no stall, rf_we = 0 next cycle, misalign_err pulses for 1 cycle.
- Store lanes: SB sets be = 0001 << addr[1:0] with the byte replicated 4x. SH sets be = 0011 << addr[1:0] with the half replicated 2x. SW sets be = 1111.
- Load format: pick the byte/half at addr[1:0] from dmem_rdata. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM IDLE: on a valid mem op, drive dmem_req combinationally from the inputs and latch addr/ctl/wdata.
  - Store with gnt: stay IDLE, no stall.
  - Store without gnt: go to WAIT_GNT.
  - Load with gnt: go to WAIT_RVALID.
  - Load without gnt: go to WAIT_GNT.
  - lsu_stall is high in IDLE for every case except a store with gnt.
- FSM WAIT_GNT: dmem_req is held high with the latched values, which must be stable.
  - On gnt, a store returns to IDLE and a load goes to WAIT_RVALID.
  - lsu_stall = ~(gnt && store).
- FSM WAIT_RVALID: dmem_req = 0; lsu_stall = ~rvalid.
  - On rvalid: register rf_wdata (formatted load if Memtoreg = 01, else latched alu_result) and rf_we per the rules above, then return to IDLE.
  - The upstream stages advance on that same edge.
- Gnt and rvalid in the same cycle in IDLE are illegal. rvalid is ignored outside WAIT_RVALID, including any stale response after a reset.
- Watchdog: the count clears on entering a wait state and increments each wait cycle. When TIMEOUT != 0 and count == TIMEOUT-1 without progress:
  - return to IDLE, deassert req and stall;
  - bus_err pulses, rf_we = 0.
- rf_we is a single-cycle pulse per instruction. Async reset mid-access aborts it with no writeback.

Decomposition:
- Package lsu_pkg holds the Ld/St/Memtoreg encodings, the FSM state enum, and the lane-mask constants.
- One combinational sub-module, load_align, takes (rdata, offset[1:0], Ld_cntr) and returns the 32-bit extended data.
- The FSM, watchdog, store-lane logic and writeback registers stay in lsu_wb.

Test Plan:
- ALU op alu_result = 0x1234, RegW = 1, wr_addr = 5 -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234, stall never high. Same with wr_addr = 0 -> rf_we = 0.
- SB addr 0x103, Rd2 = 0xAB, gnt same cycle -> dmem_addr = 0x100, be = 1000, wdata = 0xABABABAB, lsu_stall = 0, no rf_we.
- LB addr 0x102, Memtoreg = 01, gnt after 2 cycles, rvalid 1 cycle later with rdata = 0x0080FF00 -> stall high 3 cycles, then rf_wdata = 0xFFFFFF80. The same access as LBU gives 0x00000080.
- LW addr 0x102 -> no dmem_req, misalign_err pulse 1 cycle, rf_we = 0. SH addr 0x101 -> same.
- TIMEOUT = 4, load with gnt never asserted -> stall high 4 cycles, bus_err pulse, return to IDLE, rf_we = 0. A late rvalid is then ignored.
- rstn low while in WAIT_RVALID -> all outputs 0 immediately. An rvalid after rstn rises produces no rf_we.
